// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM encoding and index-width helper for the systolic matmul engine
package systolic_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    DRAIN = 4'b0100,
    OUT   = 4'b1000
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary MAC cell, a flows right and b flows down
module systolic_pe #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] a_i,
  input  logic               a_v_i,
  input  logic [width_p-1:0] b_i,
  input  logic               b_v_i,
  output logic [width_p-1:0] a_o,
  output logic               a_v_o,
  output logic [width_p-1:0] b_o,
  output logic               b_v_o,
  output logic [width_p-1:0] acc_o
);
  logic [width_p-1:0] a_q, b_q, acc_q, acc_d;
  logic               a_v_q, b_v_q;

  assign a_o   = a_q;
  assign a_v_o = a_v_q;
  assign b_o   = b_q;
  assign b_v_o = b_v_q;
  assign acc_o = acc_q;

  // product truncated to width_p, accumulation wraps modulo 2^width_p
  always_comb acc_d = (a_v_i && b_v_i) ? acc_q + a_i * b_i : acc_q;

  // clear drops in-flight operands too, so an aborted job leaves nothing behind
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      a_v_q <= 1'b0;
      b_v_q <= 1'b0;
      acc_q <= '0;
    end else if (clr_i) begin
      a_v_q <= 1'b0;
      b_v_q <= 1'b0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      a_v_q <= a_v_i;
      b_q   <= b_i;
      b_v_q <= b_v_i;
      acc_q <= acc_d;
    end
endmodule

// File: rtl/systolic_matmul.sv
// systolic_matmul: serial-stream Z = A x B on an output-stationary PE grid with valid/yumi result port
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_height_p = 2,
  parameter int array_width_p  = 2,
  parameter int depth_p        = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               accum_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               busy_o
);
  localparam int H  = array_height_p;
  localparam int W  = array_width_p;
  localparam int BL = H + W;
  localparam int N  = H * W;
  localparam int BW = idx_w(BL);
  localparam int SW = idx_w(depth_p);
  localparam int IW = idx_w(N);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(depth_p - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  state_e             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d, drain_q, drain_d;
  logic [SW-1:0]      step_q, step_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               flush, accept, drain_tick, take, tick, clr;
  logic               last_beat, last_step, drain_done, idx_last;
  logic [width_p-1:0] a_hold_q [H];
  logic               a_hv_q   [H];
  logic [H-1:0]       a_edge_v;
  logic [W-1:0]       b_edge_v;
  logic [width_p-1:0] a_w  [H][W];
  logic               a_vw [H][W];
  logic [width_p-1:0] b_w  [H][W];
  logic               b_vw [H][W];
  logic [width_p-1:0] z_w  [N];

  assign ready_o    = (state_q == IDLE) || (state_q == LOAD);
  assign valid_o    = state_q == OUT;
  assign busy_o     = state_q != IDLE;
  assign flush      = en_i & flush_i;
  assign accept     = en_i & ~flush_i & valid_i & ready_o;
  assign drain_tick = en_i & ~flush_i & (state_q == DRAIN);
  assign take       = en_i & ~flush_i & yumi_i & valid_o;
  assign tick       = accept | drain_tick;
  assign clr        = flush | (accept & (state_q == IDLE) & ~accum_i);
  assign last_beat  = beat_q == BEAT_LAST;
  assign last_step  = step_q == STEP_LAST;
  assign drain_done = drain_q == BEAT_LAST;
  assign idx_last   = idx_q == IDX_LAST;

  // counters and FSM next state; drain keeps the beat counter running so late A rows still launch
  always_comb begin
    beat_d  = flush ? '0 : tick ? (last_beat ? '0 : beat_q + 1'b1) : beat_q;
    step_d  = flush ? '0 : (accept && last_beat) ? (last_step ? '0 : step_q + 1'b1) : step_q;
    drain_d = flush ? '0 : drain_tick ? (drain_done ? '0 : drain_q + 1'b1) : drain_q;
    idx_d   = flush ? '0 : take ? (idx_last ? '0 : idx_q + 1'b1) : idx_q;
    state_d = flush                                ? IDLE  :
              (accept && last_beat && last_step)   ? DRAIN :
              (accept && state_q == IDLE)          ? LOAD  :
              (drain_tick && drain_done)           ? OUT   :
              (take && idx_last)                   ? IDLE  : state_q;
  end

  // control state registers
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      step_q  <= '0;
      drain_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
    end

  // A[r] arrives at beat r but must enter row r at beat r+H (mod step) to meet B skewed by column
  always_comb begin
    a_edge_v = '0;
    for (int r = 0; r < H; r++) a_edge_v[r] = tick & a_hv_q[r] & (beat_q == BW'((r + H) % BL));
  end

  // B[c] enters column c directly on the beat it arrives
  always_comb begin
    b_edge_v = '0;
    for (int c = 0; c < W; c++) b_edge_v[c] = accept & (beat_q == BW'(H + c));
  end

  // A skew holding registers with a pending flag cleared on launch
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      for (int r = 0; r < H; r++) begin
        a_hold_q[r] <= '0;
        a_hv_q[r]   <= 1'b0;
      end
    end else begin
      for (int r = 0; r < H; r++) begin
        if (flush) a_hv_q[r] <= 1'b0;
        else if (accept && beat_q == BW'(r)) begin
          a_hold_q[r] <= data_i;
          a_hv_q[r]   <= 1'b1;
        end else if (a_edge_v[r]) a_hv_q[r] <= 1'b0;
      end
    end

  for (genvar r = 0; r < H; r++) begin : g_row
    for (genvar c = 0; c < W; c++) begin : g_col
      logic [width_p-1:0] a_in, b_in;
      logic               a_vin, b_vin;
      if (c == 0) begin : g_a_edge
        assign a_in  = a_hold_q[r];
        assign a_vin = a_edge_v[r];
      end else begin : g_a_link
        assign a_in  = a_w[r][c-1];
        assign a_vin = a_vw[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in  = data_i;
        assign b_vin = b_edge_v[c];
      end else begin : g_b_link
        assign b_in  = b_w[r-1][c];
        assign b_vin = b_vw[r-1][c];
      end
      systolic_pe #(.width_p(width_p)) u_pe (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .en_i    (tick),
        .clr_i   (clr),
        .a_i     (a_in),
        .a_v_i   (a_vin),
        .b_i     (b_in),
        .b_v_i   (b_vin),
        .a_o     (a_w[r][c]),
        .a_v_o   (a_vw[r][c]),
        .b_o     (b_w[r][c]),
        .b_v_o   (b_vw[r][c]),
        .acc_o   (z_w[r*W+c])
      );
    end
  end

  // row-major result select, zero outside OUT
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) if (valid_o && idx_q == IW'(i)) data_o = z_w[i];
  end
endmodule
